// File: rtl/uart_pkg.sv
// Shared UART definitions: bus address nibbles, STATUS/CTRL bit positions and
// the helpers that decode an access and pack the STATUS word.
package uart_pkg;

   localparam logic [3:0] UART_DATA   = 4'h2;
   localparam logic [3:0] UART_CTRL   = 4'h3;
   localparam logic [3:0] UART_STATUS = 4'h4;

   localparam int NOT_FULL = 0;
   localparam int EMPTY    = 1;
   localparam int OVF      = 2;
   localparam int CNT_LSB  = 8;

   localparam int FLUSH    = 0;
   localparam int CLR_OVF  = 1;

   // Count field is wide enough for DEPTH = 256 (0..256).
   localparam int CNT_W    = 9;

   typedef enum logic [1:0] {
      ACC_NONE,
      ACC_DATA,
      ACC_CTRL,
      ACC_STATUS
   } acc_e;

   typedef struct packed {
      logic [CNT_W-1:0] count;
      logic             ovf;
      logic             empty;
      logic             not_full;
   } status_t;

   function automatic acc_e decode_nibble(input logic [3:0] nib);
      acc_e acc;
      case (nib)
         UART_DATA:   acc = ACC_DATA;
         UART_CTRL:   acc = ACC_CTRL;
         UART_STATUS: acc = ACC_STATUS;
         default:     acc = ACC_NONE;
      endcase
      return acc;
   endfunction

   function automatic logic [31:0] pack_status(input status_t s);
      logic [31:0] w;
      w                     = '0;
      w[NOT_FULL]           = s.not_full;
      w[EMPTY]              = s.empty;
      w[OVF]                = s.ovf;
      w[CNT_LSB +: CNT_W]   = s.count;
      return w;
   endfunction

endpackage

// File: rtl/uart_tx_buffer_sync_fifo.sv
// Single-clock circular FIFO with push/pop/flush and an occupancy count.
// Fullness is judged at cycle start, so a push into a full FIFO is refused even
// when a pop happens on the same edge.
module sync_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic             i_flush,
   input  logic [WIDTH-1:0] i_wdata,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty,
   output logic [AW:0]      o_count
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;

   logic             w_full;
   logic             w_empty;
   logic             w_push_ok;
   logic             w_pop_ok;

   assign w_full    = (r_count == FULL_CNT);
   assign w_empty   = (r_count == '0);
   // Flush takes priority and discards any same-cycle push or pop.
   assign w_push_ok = i_push && !w_full  && !i_flush;
   assign w_pop_ok  = i_pop  && !w_empty && !i_flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage carries no reset; only the pointers and count define validity.
   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[r_rd_ptr];
   assign o_full  = w_full;
   assign o_empty = w_empty;
   assign o_count = r_count;

endmodule

// File: rtl/uart_tx_buffer.sv
// Memory-mapped byte queue in front of the uart_tx serializer: DATA writes
// enqueue, CTRL flushes / clears overflow, STATUS reads report occupancy.
module uart_tx_buffer
   import uart_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic [31:0] data_in,
   input  logic        rd_strobe,
   input  logic [3:0]  wr_strobe,
   output logic [31:0] data_out,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready
);

   localparam int AW = $clog2(DEPTH);

   acc_e        w_acc;
   logic        w_wr;
   logic        w_data_wr;
   logic        w_ctrl_wr;
   logic        w_status_rd;
   logic        w_flush;
   logic        w_clr_ovf;
   logic        w_ovf_set;
   logic        w_pop;
   logic        w_full;
   logic        w_empty;
   logic [AW:0] w_count;
   logic [7:0]  w_head;
   logic [31:0] w_status;
   logic        w_unused;

   logic        r_ovf;
   logic [31:0] r_data_out;

   assign w_acc       = decode_nibble(addr[31:28]);
   assign w_wr        = |wr_strobe;
   assign w_data_wr   = w_wr && (w_acc == ACC_DATA);
   assign w_ctrl_wr   = w_wr && (w_acc == ACC_CTRL);
   assign w_status_rd = rd_strobe && (w_acc == ACC_STATUS);
   assign w_flush     = w_ctrl_wr && data_in[FLUSH];
   assign w_clr_ovf   = w_ctrl_wr && data_in[CLR_OVF];
   assign w_ovf_set   = w_data_wr && w_full;
   assign w_pop       = !w_empty && tx_ready;

   // Only the top address nibble and the low data byte carry meaning here.
   assign w_unused    = ^{addr[27:0], data_in[31:8]};

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst),
      .i_push  (w_data_wr),
      .i_pop   (w_pop),
      .i_flush (w_flush),
      .i_wdata (data_in[7:0]),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   // Set beats clear if both ever coincide.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ovf <= 1'b0;
      end else if (w_ovf_set) begin
         r_ovf <= 1'b1;
      end else if (w_clr_ovf) begin
         r_ovf <= 1'b0;
      end
   end

   assign w_status = pack_status('{
      count:    CNT_W'(w_count),
      ovf:      r_ovf,
      empty:    w_empty,
      not_full: !w_full
   });

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_data_out <= '0;
      end else if (w_status_rd) begin
         r_data_out <= w_status;
      end
   end

   assign data_out = r_data_out;
   assign tx_valid = !w_empty;
   assign tx_data  = w_head;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Bench for uart_tx_buffer: a fixed vector table, directed corner sequences and
// a randomized phase checked against a queue-based model of the byte FIFO.
module tb_uart_tx_buffer;

   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr;
   logic [31:0] data_in;
   logic        rd_strobe;
   logic [3:0]  wr_strobe;
   logic [31:0] data_out;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;

   always #5 clk = ~clk;

   uart_tx_buffer #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .addr      (addr),
      .data_in   (data_in),
      .rd_strobe (rd_strobe),
      .wr_strobe (wr_strobe),
      .data_out  (data_out),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0]  mq[$];
   logic        m_ovf;
   logic [31:0] m_dout;
   logic [7:0]  emit[$];

   typedef struct {
      logic [3:0]  nib;
      logic [31:0] din;
      bit          wr;
      bit          rd;
      bit          rdy;
      bit          exp_vld;
      logic [7:0]  exp_txd;
      logic [31:0] exp_dout;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_status();
      int n;
      n = mq.size();
      return 32'((n < DEPTH) ? 1 : 0) | 32'((n == 0) ? 2 : 0) |
             32'(m_ovf ? 4 : 0) | 32'(n * 256);
   endfunction

   task automatic model_reset();
      mq.delete();
      m_ovf  = 1'b0;
      m_dout = 32'h0;
   endtask

   task automatic set_bus(input logic [3:0] nib, input logic [31:0] din,
                          input bit wr, input bit rd, input bit rdy);
      addr      = {nib, 28'h0};
      data_in   = din;
      wr_strobe = wr ? 4'hF : 4'h0;
      rd_strobe = rd;
      tx_ready  = rdy;
   endtask

   task automatic check_model();
      chk("tx_valid", {31'h0, tx_valid}, {31'h0, mq.size() != 0});
      if (mq.size() != 0) chk("tx_data", {24'h0, tx_data}, {24'h0, mq[0]});
      chk("data_out", data_out, m_dout);
   endtask

   // Advance one clock: log the DUT handshake, step the model, then compare.
   task automatic tick();
      bit         wr;
      bit         full;
      bit         popm;
      logic [3:0] nib;
      wr   = |wr_strobe;
      nib  = addr[31:28];
      if (tx_valid && tx_ready) emit.push_back(tx_data);
      full = (mq.size() == DEPTH);
      popm = (mq.size() != 0) && tx_ready;
      if (rd_strobe && nib == 4'h4) m_dout = model_status();
      if (wr && nib == 4'h2 && full) m_ovf = 1'b1;
      else if (wr && nib == 4'h3 && data_in[1]) m_ovf = 1'b0;
      if (wr && nib == 4'h3 && data_in[0]) begin
         mq.delete();
      end else begin
         if (popm) void'(mq.pop_front());
         if (wr && nib == 4'h2 && !full) mq.push_back(data_in[7:0]);
      end
      @(posedge clk);
      #1;
      check_model();
   endtask

   task automatic idle(input bit rdy, input int n);
      for (int i = 0; i < n; i++) begin
         set_bus(4'h0, 32'h0, 1'b0, 1'b0, rdy);
         tick();
      end
   endtask

   task automatic wr_data(input logic [7:0] b, input bit rdy);
      set_bus(4'h2, {24'h0, b}, 1'b1, 1'b0, rdy);
      tick();
   endtask

   task automatic wr_ctrl(input logic [31:0] v);
      set_bus(4'h3, v, 1'b1, 1'b0, 1'b0);
      tick();
   endtask

   task automatic rd_status(input string name, input logic [31:0] exp);
      set_bus(4'h4, 32'h0, 1'b0, 1'b1, 1'b0);
      tick();
      chk(name, data_out, exp);
   endtask

   task automatic chk_emit(input string name, input int base, input int n);
      chk({name, "_len"}, 32'(emit.size()), 32'(n));
      for (int i = 0; i < n; i++) begin
         if (i < emit.size()) chk(name, {24'h0, emit[i]}, 32'(base + i));
      end
      emit.delete();
   endtask

   initial begin
      logic [31:0] rnd;
      logic [31:0] din;
      int          r;

      vecs[0] = '{4'h4, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 32'h0000_0003};
      vecs[1] = '{4'h2, 32'h41, 1'b1, 1'b0, 1'b0, 1'b1, 8'h41, 32'h0000_0003};
      vecs[2] = '{4'h4, 32'h0,  1'b0, 1'b1, 1'b0, 1'b1, 8'h41, 32'h0000_0101};
      vecs[3] = '{4'h0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 32'h0000_0101};
      vecs[4] = '{4'h4, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 32'h0000_0003};
      vecs[5] = '{4'h2, 32'h7E, 1'b1, 1'b0, 1'b0, 1'b1, 8'h7E, 32'h0000_0003};
      vecs[6] = '{4'h2, 32'h99, 1'b1, 1'b0, 1'b1, 1'b1, 8'h99, 32'h0000_0003};
      vecs[7] = '{4'h4, 32'h0,  1'b0, 1'b1, 1'b0, 1'b1, 8'h99, 32'h0000_0101};
      vecs[8] = '{4'h3, 32'h1,  1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0000_0101};
      vecs[9] = '{4'h4, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 32'h0000_0003};

      set_bus(4'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("reset_valid", {31'h0, tx_valid}, 32'h0);
      chk("reset_dout", data_out, 32'h0);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 10; i++) begin
         set_bus(vecs[i].nib, vecs[i].din, vecs[i].wr, vecs[i].rd, vecs[i].rdy);
         tick();
         chk($sformatf("vec%0d_valid", i), {31'h0, tx_valid}, {31'h0, vecs[i].exp_vld});
         if (vecs[i].exp_vld) chk($sformatf("vec%0d_txd", i), {24'h0, tx_data}, {24'h0, vecs[i].exp_txd});
         chk($sformatf("vec%0d_dout", i), data_out, vecs[i].exp_dout);
      end
      emit.delete();

      // Fill, overflow, drain in order
      for (int i = 0; i < DEPTH; i++) wr_data(8'(i), 1'b0);
      rd_status("fill_status", 32'h0000_1000);
      wr_data(8'hAA, 1'b0);
      rd_status("ovf_status", 32'h0000_1004);
      idle(1'b1, DEPTH + 2);
      chk_emit("fill_drain", 0, DEPTH);
      wr_ctrl(32'h2);
      rd_status("clr_ovf_status", 32'h0000_0003);

      // Streaming with concurrent pops and pointer wrap
      for (int i = 0; i < 40; i++) wr_data(8'(i), 1'b1);
      idle(1'b1, 3);
      chk_emit("wrap_stream", 0, 40);
      rd_status("wrap_status", 32'h0000_0003);

      // Push into a full FIFO while popping
      for (int i = 0; i < DEPTH; i++) wr_data(8'(8'h80 + i), 1'b0);
      wr_data(8'h55, 1'b1);
      rd_status("full_pop_status", 32'h0000_0F05);
      idle(1'b1, DEPTH + 2);
      chk_emit("full_pop_drain", 32'h80, DEPTH);

      // Flush keeps overflow; clear overflow afterwards
      for (int i = 0; i < 5; i++) wr_data(8'(8'h30 + i), 1'b0);
      rd_status("pre_flush_status", 32'h0000_0505);
      wr_ctrl(32'h1);
      chk("flush_valid", {31'h0, tx_valid}, 32'h0);
      rd_status("post_flush_status", 32'h0000_0007);
      wr_ctrl(32'h2);
      rd_status("post_clr_status", 32'h0000_0003);

      // Flush while a pop is pending discards the pop
      for (int i = 0; i < 3; i++) wr_data(8'(8'h60 + i), 1'b0);
      set_bus(4'h3, 32'h1, 1'b1, 1'b0, 1'b1);
      tick();
      rd_status("flush_pop_status", 32'h0000_0003);
      emit.delete();

      // Randomized traffic against the model
      for (int c = 0; c < 600; c++) begin
         r   = $urandom_range(0, 99);
         rnd = $urandom();
         din = $urandom();
         if (r < 45) begin
            addr = {4'h2, rnd[27:0]};
            wr_strobe = 4'($urandom_range(1, 15));
            rd_strobe = 1'b0;
         end else if (r < 52) begin
            if ($urandom_range(0, 3) != 0) din[0] = 1'b0;
            addr = {4'h3, rnd[27:0]};
            wr_strobe = 4'($urandom_range(1, 15));
            rd_strobe = 1'b0;
         end else if (r < 75) begin
            addr = {4'h4, rnd[27:0]};
            wr_strobe = 4'h0;
            rd_strobe = 1'b1;
         end else begin
            addr = rnd;
            if (addr[31:28] inside {4'h2, 4'h3, 4'h4}) addr[31:28] = 4'h9;
            wr_strobe = 4'($urandom_range(0, 15));
            rd_strobe = $urandom_range(0, 1) == 1;
         end
         data_in  = din;
         tx_ready = ($urandom_range(0, 2) == 0);
         tick();
      end
      emit.delete();

      // Asynchronous reset in the middle of a drain
      wr_ctrl(32'h3);
      for (int i = 0; i < 8; i++) wr_data(8'(8'hC0 + i), 1'b0);
      idle(1'b1, 2);
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      chk("async_rst_valid", {31'h0, tx_valid}, 32'h0);
      chk("async_rst_dout", data_out, 32'h0);
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      rd_status("post_rst_status", 32'h0000_0003);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
